// File: rtl/csr_trap_seq.sv
// csr_trap_seq
//   Machine-mode trap sequencer. Detects an interrupt, exception or mret at
//   commit, then writes mepc/mcause/mtval/mstatus (or just mstatus for mret)
//   one per cycle through the CSR file's single write port, and finishes with
//   a one-cycle PC redirect. While idle it forwards the pipeline's own CSR
//   writes, so it also arbitrates the write port.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   valid, ins_pc, ins_tval  committing instruction and its fault value
//   <exception flags>, m_ret commit events, qualified by valid
//   int_req                  level external interrupt request
//   mstatus_in/mtvec_in/mepc_in  current CSR values
//   cpu_csr_*                pipeline write request; cpu_csr_stall = not taken
//   csr_write/_index/_data_w CSR file write port
//   trap_busy                sequence in progress
//   int_acc                  one-cycle pulse when an interrupt is taken
//   redirect, redirect_pc    one-cycle PC redirect
module csr_trap_seq #(
    parameter int INT_CAUSE = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] ins_pc,
    input  logic [31:0] ins_tval,
    input  logic        ins_addr_mis,
    input  logic        ins_acc_fault,
    input  logic        ins_page_fault,
    input  logic        ill_ins,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        ld_addr_mis,
    input  logic        st_addr_mis,
    input  logic        ld_acc_fault,
    input  logic        st_acc_fault,
    input  logic        ld_page_fault,
    input  logic        st_page_fault,
    input  logic        m_ret,
    input  logic        int_req,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        cpu_csr_write,
    input  logic [11:0] cpu_csr_index,
    input  logic [31:0] cpu_csr_wdata,
    output logic        cpu_csr_stall,
    output logic        csr_write,
    output logic [11:0] csr_write_index,
    output logic [31:0] csr_data_w,
    output logic        trap_busy,
    output logic        int_acc,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EPC     = 3'd1;
    localparam logic [2:0] S_CAUSE   = 3'd2;
    localparam logic [2:0] S_TVAL    = 3'd3;
    localparam logic [2:0] S_STATUS  = 3'd4;
    localparam logic [2:0] S_RSTATUS = 3'd5;
    localparam logic [2:0] S_REDIR   = 3'd6;

    logic [2:0]  state, state_nx;
    logic [31:0] cap_pc, cap_tval, cap_tgt, cap_mstatus;
    logic [30:0] cap_cause;
    logic        cap_int;

    logic        idle, exc_any, take_int, take_trap, take_mret;
    logic [30:0] exc_cause, trap_cause;
    logic [31:0] trap_tval, trap_tgt;

    assign idle    = (state == S_IDLE);
    assign exc_any = valid & (ins_addr_mis | ins_acc_fault | ins_page_fault | ill_ins |
                              ecall | ebreak | ld_addr_mis | st_addr_mis |
                              ld_acc_fault | st_acc_fault | ld_page_fault | st_page_fault);

    // Interrupt wins over everything and needs no committing instruction.
    assign take_int  = idle & int_req & mstatus_in[3];
    assign take_trap = idle & ((int_req & mstatus_in[3]) | exc_any);
    assign take_mret = idle & valid & m_ret & ~exc_any & ~(int_req & mstatus_in[3]);

    always_comb begin
        exc_cause = 31'd0;
        if      (ins_page_fault) exc_cause = 31'd12;
        else if (ins_acc_fault)  exc_cause = 31'd1;
        else if (ill_ins)        exc_cause = 31'd2;
        else if (ins_addr_mis)   exc_cause = 31'd0;
        else if (ecall)          exc_cause = 31'd11;
        else if (ebreak)         exc_cause = 31'd3;
        else if (st_addr_mis)    exc_cause = 31'd6;
        else if (ld_addr_mis)    exc_cause = 31'd4;
        else if (st_page_fault)  exc_cause = 31'd15;
        else if (ld_page_fault)  exc_cause = 31'd13;
        else if (st_acc_fault)   exc_cause = 31'd7;
        else if (ld_acc_fault)   exc_cause = 31'd5;
    end

    assign trap_cause = take_int ? 31'(INT_CAUSE) : exc_cause;

    // Exception causes 11 and 3 are only ever ecall/ebreak, which carry no tval.
    assign trap_tval = (take_int || exc_cause == 31'd11 || exc_cause == 31'd3) ? 32'd0 : ins_tval;

    // Vectored mode only offsets interrupts; exceptions always land on base.
    assign trap_tgt = {mtvec_in[31:2], 2'b00} +
                      ((take_int && mtvec_in[1:0] == 2'b01) ? (32'(trap_cause) << 2) : 32'd0);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (take_trap)      state_nx = S_EPC;
                else if (take_mret) state_nx = S_RSTATUS;
            end
            S_EPC:     state_nx = S_CAUSE;
            S_CAUSE:   state_nx = S_TVAL;
            S_TVAL:    state_nx = S_STATUS;
            S_STATUS:  state_nx = S_REDIR;
            S_RSTATUS: state_nx = S_REDIR;
            S_REDIR:   state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            trap_busy   <= 1'b0;
            int_acc     <= 1'b0;
            cap_pc      <= 32'd0;
            cap_tval    <= 32'd0;
            cap_tgt     <= 32'd0;
            cap_mstatus <= 32'd0;
            cap_cause   <= 31'd0;
            cap_int     <= 1'b0;
        end else begin
            state     <= state_nx;
            trap_busy <= (state_nx != S_IDLE);
            int_acc   <= take_int;
            if (take_trap) begin
                cap_pc      <= ins_pc;
                cap_tval    <= trap_tval;
                cap_tgt     <= trap_tgt;
                cap_mstatus <= mstatus_in;
                cap_cause   <= trap_cause;
                cap_int     <= take_int;
            end else if (take_mret) begin
                cap_tgt <= mepc_in;
            end
        end
    end

    always_comb begin
        cpu_csr_stall   = 1'b0;
        csr_write       = 1'b0;
        csr_write_index = 12'h000;
        csr_data_w      = 32'd0;
        redirect        = 1'b0;
        redirect_pc     = 32'd0;
        if (!idle) cpu_csr_stall = cpu_csr_write;
        case (state)
            S_IDLE: begin
                // A detected trap/mret drops the faulting instruction's write.
                if (!take_trap && !take_mret) begin
                    csr_write       = cpu_csr_write;
                    csr_write_index = cpu_csr_index;
                    csr_data_w      = cpu_csr_wdata;
                end
            end
            S_EPC: begin
                csr_write       = 1'b1;
                csr_write_index = 12'h341;
                csr_data_w      = cap_pc & 32'hFFFF_FFFC;
            end
            S_CAUSE: begin
                csr_write       = 1'b1;
                csr_write_index = 12'h342;
                csr_data_w      = {cap_int, cap_cause};
            end
            S_TVAL: begin
                csr_write       = 1'b1;
                csr_write_index = 12'h343;
                csr_data_w      = cap_tval;
            end
            S_STATUS: begin
                csr_write       = 1'b1;
                csr_write_index = 12'h300;
                csr_data_w      = cap_mstatus;
                csr_data_w[7]   = cap_mstatus[3];
                csr_data_w[3]   = 1'b0;
                csr_data_w[12:11] = 2'b11;
            end
            S_RSTATUS: begin
                csr_write       = 1'b1;
                csr_write_index = 12'h300;
                csr_data_w      = mstatus_in;
                csr_data_w[3]   = mstatus_in[7];
                csr_data_w[7]   = 1'b1;
            end
            S_REDIR: begin
                redirect    = 1'b1;
                redirect_pc = cap_tgt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
module tb_csr_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] ins_pc, ins_tval;
    logic [11:0] exc; // index = priority rank, 0 highest
    logic        m_ret, int_req;
    logic [31:0] mstatus_in, mtvec_in, mepc_in;
    logic        cpu_csr_write;
    logic [11:0] cpu_csr_index;
    logic [31:0] cpu_csr_wdata;
    logic        cpu_csr_stall, csr_write, trap_busy, int_acc, redirect;
    logic [11:0] csr_write_index;
    logic [31:0] csr_data_w, redirect_pc;

    int total = 0;
    int bad   = 0;

    // cause codes listed in priority order, matching exc[] bit ranks
    int prio_cause [12] = '{12, 1, 2, 0, 11, 3, 6, 4, 15, 13, 7, 5};

    always #5 clk = ~clk;

    csr_trap_seq #(.INT_CAUSE(11)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ins_pc(ins_pc), .ins_tval(ins_tval),
        .ins_page_fault(exc[0]), .ins_acc_fault(exc[1]), .ill_ins(exc[2]),
        .ins_addr_mis(exc[3]), .ecall(exc[4]), .ebreak(exc[5]),
        .st_addr_mis(exc[6]), .ld_addr_mis(exc[7]), .st_page_fault(exc[8]),
        .ld_page_fault(exc[9]), .st_acc_fault(exc[10]), .ld_acc_fault(exc[11]),
        .m_ret(m_ret), .int_req(int_req),
        .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .cpu_csr_write(cpu_csr_write), .cpu_csr_index(cpu_csr_index),
        .cpu_csr_wdata(cpu_csr_wdata), .cpu_csr_stall(cpu_csr_stall),
        .csr_write(csr_write), .csr_write_index(csr_write_index), .csr_data_w(csr_data_w),
        .trap_busy(trap_busy), .int_acc(int_acc), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic quiet();
        valid = 0; exc = '0; m_ret = 0; int_req = 0; cpu_csr_write = 0;
    endtask

    // Reference model: what the trap rules say should happen for the current inputs.
    task automatic model(output logic take, output logic is_int, output logic [30:0] cause,
                         output logic [31:0] tval, output logic [31:0] tgt, output logic mret);
        take = 0; is_int = 0; cause = 0; tval = 0; mret = 0;
        if (int_req && mstatus_in[3]) begin
            take = 1; is_int = 1; cause = 11; tval = 0;
        end else if (valid && exc != 0) begin
            take = 1;
            for (int i = 11; i >= 0; i--)
                if (exc[i]) cause = 31'(prio_cause[i]);
            tval = (cause == 11 || cause == 3) ? 32'd0 : ins_tval;
        end else if (valid && m_ret) begin
            mret = 1;
        end
        tgt = (mtvec_in & ~32'd3) + ((is_int && mtvec_in[1:0] == 2'd1) ? 32'(cause) * 4 : 32'd0);
        if (mret) tgt = mepc_in;
    endtask

    // Inputs for the detection cycle must already be driven (posedge + 1).
    task automatic run_trap(input string nm, input logic is_int, input logic [30:0] cause,
                            input logic [31:0] tval, input logic [31:0] tgt);
        logic [31:0] pc, mst, st, dat;
        logic [11:0] idx;
        pc = ins_pc; mst = mstatus_in;
        st = mst; st[7] = mst[3]; st[3] = 1'b0; st[12:11] = 2'b11;
        cpu_csr_write = 1; cpu_csr_index = 12'h123; cpu_csr_wdata = $urandom;
        #1;
        total++;
        if (csr_write !== 1'b0 || cpu_csr_stall !== 1'b0) begin
            bad++; $display("FAIL %s detect_drop got wr=%b stall=%b exp wr=0 stall=0", nm, csr_write, cpu_csr_stall);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            valid = 0; exc = '0; m_ret = 0; int_req = 0;
            cpu_csr_index = 12'(k); cpu_csr_wdata = $urandom;
            #1;
            case (k)
                1: begin idx = 12'h341; dat = pc & 32'hFFFF_FFFC; end
                2: begin idx = 12'h342; dat = {is_int, cause}; end
                3: begin idx = 12'h343; dat = tval; end
                default: begin idx = 12'h300; dat = st; end
            endcase
            total++;
            if (trap_busy !== 1'b1 || cpu_csr_stall !== 1'b1 || int_acc !== (k == 1 && is_int)) begin
                bad++; $display("FAIL %s ctl_T+%0d got busy=%b stall=%b int_acc=%b exp 1 1 %b",
                                nm, k, trap_busy, cpu_csr_stall, int_acc, (k == 1 && is_int));
            end
            total++;
            if (k < 5) begin
                if (csr_write !== 1'b1 || csr_write_index !== idx || csr_data_w !== dat || redirect !== 1'b0) begin
                    bad++; $display("FAIL %s write_T+%0d got wr=%b idx=%h data=%h redir=%b exp wr=1 idx=%h data=%h redir=0",
                                    nm, k, csr_write, csr_write_index, csr_data_w, redirect, idx, dat);
                end
            end else begin
                if (csr_write !== 1'b0 || redirect !== 1'b1 || redirect_pc !== tgt) begin
                    bad++; $display("FAIL %s redirect got wr=%b redir=%b pc=%h exp wr=0 redir=1 pc=%h",
                                    nm, csr_write, redirect, redirect_pc, tgt);
                end
            end
        end
        @(posedge clk); #1;
        cpu_csr_write = 0;
        #1;
        total++;
        if (trap_busy !== 1'b0 || redirect !== 1'b0) begin
            bad++; $display("FAIL %s back_idle got busy=%b redir=%b exp 0 0", nm, trap_busy, redirect);
        end
    endtask

    task automatic run_mret(input string nm, input logic [31:0] tgt);
        logic [31:0] st;
        st = mstatus_in; st[3] = mstatus_in[7]; st[7] = 1'b1;
        cpu_csr_write = 1; cpu_csr_index = 12'h456; cpu_csr_wdata = $urandom;
        #1;
        total++;
        if (csr_write !== 1'b0 || cpu_csr_stall !== 1'b0) begin
            bad++; $display("FAIL %s detect_drop got wr=%b stall=%b exp wr=0 stall=0", nm, csr_write, cpu_csr_stall);
        end
        @(posedge clk); #1;
        valid = 0; exc = '0; m_ret = 0; int_req = 0;
        #1;
        total++;
        if (csr_write !== 1'b1 || csr_write_index !== 12'h300 || csr_data_w !== st ||
            trap_busy !== 1'b1 || cpu_csr_stall !== 1'b1) begin
            bad++; $display("FAIL %s rstatus got wr=%b idx=%h data=%h busy=%b stall=%b exp 1 300 %h 1 1",
                            nm, csr_write, csr_write_index, csr_data_w, trap_busy, cpu_csr_stall, st);
        end
        @(posedge clk); #2;
        total++;
        if (redirect !== 1'b1 || redirect_pc !== tgt || csr_write !== 1'b0) begin
            bad++; $display("FAIL %s redirect got redir=%b pc=%h wr=%b exp 1 %h 0", nm, redirect, redirect_pc, csr_write, tgt);
        end
        @(posedge clk); #1;
        cpu_csr_write = 0;
        #1;
        total++;
        if (trap_busy !== 1'b0) begin
            bad++; $display("FAIL %s back_idle got busy=%b exp 0", nm, trap_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1; quiet(); ins_pc = 0; ins_tval = 0; mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
        cpu_csr_index = 0; cpu_csr_wdata = 0;
        #12;
        total++;
        if (trap_busy !== 0 || redirect !== 0 || int_acc !== 0 || csr_write !== 0 || redirect_pc !== 0) begin
            bad++; $display("FAIL reset got busy=%b redir=%b int_acc=%b wr=%b rpc=%h exp all 0",
                            trap_busy, redirect, int_acc, csr_write, redirect_pc);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_ecall();
        @(posedge clk); #1;
        quiet(); valid = 1; exc[4] = 1; ins_pc = 32'h100; ins_tval = 32'hDEAD_BEEF;
        mtvec_in = 32'h2001; mstatus_in = 32'h8;
        // 0x300 data from the model is 0x1880 for mstatus 0x8
        run_trap("ecall", 0, 31'd11, 32'd0, 32'h2000);
    endtask

    task automatic test_interrupt();
        @(posedge clk); #1;
        quiet(); int_req = 1; ins_pc = 32'h4444; mtvec_in = 32'h2001; mstatus_in = 32'h8;
        run_trap("interrupt", 1, 31'd11, 32'd0, 32'h202C);
    endtask

    task automatic test_mret();
        @(posedge clk); #1;
        quiet(); valid = 1; m_ret = 1; mstatus_in = 32'h80; mepc_in = 32'h344;
        run_mret("mret", 32'h344); // expected mstatus write 0x88
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        quiet(); valid = 1; exc[7] = 1; exc[8] = 1; exc[2] = 1;
        ins_pc = 32'h800; ins_tval = 32'h0BAD_C0DE; mtvec_in = 32'h3000; mstatus_in = 32'h0;
        run_trap("priority", 0, 31'd2, 32'h0BAD_C0DE, 32'h3000);
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            quiet(); cpu_csr_write = 1; cpu_csr_index = 12'($urandom); cpu_csr_wdata = $urandom;
            #1;
            total++;
            if (csr_write !== 1'b1 || csr_write_index !== cpu_csr_index || csr_data_w !== cpu_csr_wdata ||
                cpu_csr_stall !== 1'b0) begin
                bad++; $display("FAIL passthrough got wr=%b idx=%h data=%h stall=%b exp 1 %h %h 0",
                                csr_write, csr_write_index, csr_data_w, cpu_csr_stall, cpu_csr_index, cpu_csr_wdata);
            end
        end
        @(posedge clk); #1; quiet();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        quiet(); valid = 1; exc[4] = 1; ins_pc = 32'h500; mtvec_in = 32'h1000; mstatus_in = 32'h8;
        @(posedge clk); #1; quiet();
        @(posedge clk); #1;
        total++;
        if (csr_write !== 1'b1 || csr_write_index !== 12'h342) begin
            bad++; $display("FAIL rst_mid_pre got wr=%b idx=%h exp 1 342", csr_write, csr_write_index);
        end
        rst = 1; #1;
        total++;
        if (trap_busy !== 0 || csr_write !== 0 || redirect !== 0) begin
            bad++; $display("FAIL rst_mid_async got busy=%b wr=%b redir=%b exp 0 0 0", trap_busy, csr_write, redirect);
        end
        @(negedge clk); rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            total++;
            if (trap_busy !== 0 || csr_write !== 0 || redirect !== 0) begin
                bad++; $display("FAIL rst_mid_no_resume cyc%0d got busy=%b wr=%b redir=%b exp 0 0 0",
                                k, trap_busy, csr_write, redirect);
            end
        end
        @(posedge clk); #1;
        quiet(); valid = 1; exc[4] = 1; ins_pc = 32'h600; mtvec_in = 32'h1001; mstatus_in = 32'h0;
        run_trap("after_reset_ecall", 0, 31'd11, 32'd0, 32'h1000);
    endtask

    task automatic test_random();
        logic take, is_int, mret;
        logic [30:0] cause;
        logic [31:0] tval, tgt;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            quiet();
            valid = ($urandom_range(3) != 0);
            for (int b = 0; b < 12; b++) exc[b] = ($urandom_range(9) == 0);
            m_ret = ($urandom_range(2) == 0);
            int_req = ($urandom_range(4) == 0);
            ins_pc = $urandom; ins_tval = $urandom;
            mstatus_in = $urandom; mtvec_in = $urandom; mepc_in = $urandom;
            model(take, is_int, cause, tval, tgt, mret);
            if (take) run_trap("random_trap", is_int, cause, tval, tgt);
            else if (mret) run_mret("random_mret", tgt);
            else begin
                cpu_csr_write = $urandom_range(1); cpu_csr_index = 12'($urandom); cpu_csr_wdata = $urandom;
                #1;
                total++;
                if (csr_write !== cpu_csr_write || cpu_csr_stall !== 1'b0 ||
                    (cpu_csr_write && (csr_write_index !== cpu_csr_index || csr_data_w !== cpu_csr_wdata))) begin
                    bad++; $display("FAIL random_idle got wr=%b idx=%h data=%h stall=%b exp %b %h %h 0",
                                    csr_write, csr_write_index, csr_data_w, cpu_csr_stall,
                                    cpu_csr_write, cpu_csr_index, cpu_csr_wdata);
                end
                @(posedge clk); #1; quiet(); #1;
                total++;
                if (trap_busy !== 1'b0) begin
                    bad++; $display("FAIL random_no_trap got busy=%b exp 0", trap_busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_ecall();
        test_interrupt();
        test_mret();
        test_priority();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
